// File: rtl/store_narrow_rmw.sv
// Store-narrowing unit: performs sb/sh/sw into a 32-bit synchronous RAM,
// merging sub-word stores into the addressed big-endian lane via read-modify-write.
module store_narrow_rmw #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic [1:0]        SIZE,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [31:0]       MEM_RDATA,
  output logic [31:0]       MEM_WDATA,
  output logic              MEM_WE
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t      state;
  logic        half_q;
  logic [1:0]  off_q;
  logic [15:0] data_q;
  logic        bad;
  logic [31:0] merged;

  // Address bits above the memory size wrap and are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^ADDR[31:ADDR_W+2];

  // Request validation: reserved size or misaligned halfword/word.
  always_comb begin
    bad = 1'b0;
    case (SIZE)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = ADDR[0];
      SIZE_WORD: bad = (ADDR[1:0] != 2'b00);
      default:   bad = 1'b1;
    endcase
  end

  // Lane merge of the truncated operand into the read word (big-endian lanes).
  always_comb begin
    merged = MEM_RDATA;
    if (half_q) begin
      if (off_q[1]) merged[15:0]  = data_q;
      else          merged[31:16] = data_q;
    end else begin
      case (off_q)
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      half_q    <= 1'b0;
      off_q     <= 2'b00;
      data_q    <= '0;
    end else begin
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      MEM_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            if (bad) begin
              ERR <= 1'b1;
            end else begin
              MEM_ADDR <= ADDR[ADDR_W+1:2];
              half_q   <= SIZE[0];
              off_q    <= ADDR[1:0];
              data_q   <= WDATA[15:0];
              BUSY     <= 1'b1;
              if (SIZE == SIZE_WORD) begin
                // Full-word store needs no read; write immediately.
                MEM_WDATA <= WDATA;
                MEM_WE    <= 1'b1;
                DONE      <= 1'b1;
                state     <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          MEM_WDATA <= merged;
          MEM_WE    <= 1'b1;
          DONE      <= 1'b1;
          state     <= WRITE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Self-checking bench for store_narrow_rmw: directed scenarios plus random
// stores checked against a byte-level memory model.
module tb_store_narrow_rmw;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic        tb_we;
  logic [7:0]  tb_waddr;
  logic [31:0] tb_wdata;

  store_narrow_rmw #(.ADDR_W(8)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .SIZE(size), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .ERR(err), .MEM_ADDR(mem_addr),
    .MEM_RDATA(mem_rdata), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM; the bench port is used only for preloading.
  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic bit is_valid(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd0) return 1'b1;
    if (s == 2'd1) return a[0] == 1'b0;
    if (s == 2'd2) return a[1:0] == 2'b00;
    return 1'b0;
  endfunction

  // Reference store: replace the addressed big-endian lane with the low bits.
  function automatic logic [31:0] model_store(input logic [1:0] s, input logic [31:0] a,
                                              input logic [31:0] d);
    int          idx;
    int          shift;
    logic [31:0] mask;
    idx = int'(a[9:2]);
    if (s == 2'd2) begin
      ref_mem[idx] = d;
    end else begin
      if (s == 2'd0) begin
        shift = 8 * (3 - int'(a[1:0]));
        mask  = 32'hFF << shift;
      end else begin
        shift = 16 * (1 - int'(a[1]));
        mask  = 32'hFFFF << shift;
      end
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << shift) & mask);
    end
    return ref_mem[idx];
  endfunction

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and record what the DUT does over the next six cycles.
  task automatic apply_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                             output int we_cyc, output int err_cyc, output logic [7:0] wa,
                             output logic [31:0] wd, output logic [6:1] busy_seq,
                             output int anomalies);
    we_cyc = -1; err_cyc = -1; wa = '0; wd = '0; busy_seq = '0; anomalies = 0;
    req = 1'b1; size = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      busy_seq[k] = busy;
      if (mem_we === 1'b1) begin
        if (we_cyc < 0) begin we_cyc = k; wa = mem_addr; wd = mem_wdata; end
        else anomalies++;
      end
      if (err === 1'b1) begin
        if (err_cyc < 0) err_cyc = k;
        else anomalies++;
      end
      if (done !== mem_we || (done === 1'b1 && err === 1'b1)) anomalies++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; size = '0; addr = '0; wdata = '0; tb_we = 1'b0;
    tb_waddr = '0; tb_wdata = '0;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    checks++;
    if ({busy, done, err, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, mem_we});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset got %b want 0000", {busy, done, err, mem_we});
    end
  endtask

  task automatic test_plan_stores();
    int we_cyc, err_cyc, an; logic [7:0] wa; logic [31:0] wd, exp; logic [6:1] bs;
    preload(8'd4, 32'h11223344);
    apply_store(2'd0, 32'h11, 32'hFFFFFFAA, we_cyc, err_cyc, wa, wd, bs, an);
    exp = model_store(2'd0, 32'h11, 32'hFFFFFFAA);
    checks++;
    if (we_cyc !== 3 || wa !== 8'd4 || wd !== 32'h11AA3344 || wd !== exp) begin
      errors++; $display("FAIL sb_plan got cyc=%0d addr=%0d data=%h want cyc=3 addr=4 data=%h", we_cyc, wa, wd, exp);
    end
    checks++;
    if (bs !== 6'b000111 || an !== 0 || err_cyc !== -1) begin
      errors++; $display("FAIL sb_plan_ctrl got busy=%b anomalies=%0d err=%0d want 000111/0/-1", bs, an, err_cyc);
    end
    preload(8'd4, 32'h11223344);
    apply_store(2'd1, 32'h12, 32'h1234BEEF, we_cyc, err_cyc, wa, wd, bs, an);
    exp = model_store(2'd1, 32'h12, 32'h1234BEEF);
    checks++;
    if (we_cyc !== 3 || wa !== 8'd4 || wd !== 32'h1122BEEF || wd !== exp) begin
      errors++; $display("FAIL sh_plan got cyc=%0d addr=%0d data=%h want cyc=3 addr=4 data=%h", we_cyc, wa, wd, exp);
    end
    apply_store(2'd2, 32'h10, 32'hDEADBEEF, we_cyc, err_cyc, wa, wd, bs, an);
    exp = model_store(2'd2, 32'h10, 32'hDEADBEEF);
    checks++;
    if (we_cyc !== 1 || wa !== 8'd4 || wd !== exp || bs !== 6'b000001 || an !== 0) begin
      errors++; $display("FAIL sw_plan got cyc=%0d addr=%0d data=%h busy=%b want cyc=1 addr=4 data=%h busy=000001", we_cyc, wa, wd, bs, exp);
    end
    checks++;
    if (ram[4] !== ref_mem[4]) begin
      errors++; $display("FAIL sw_plan_mem got %h want %h", ram[4], ref_mem[4]);
    end
  endtask

  task automatic test_errors();
    int we_cyc, err_cyc, an; logic [7:0] wa; logic [31:0] wd; logic [6:1] bs;
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    sz[0] = 2'd1; ad[0] = 32'h13;
    sz[1] = 2'd2; ad[1] = 32'h12;
    sz[2] = 2'd3; ad[2] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      apply_store(sz[i], ad[i], $urandom, we_cyc, err_cyc, wa, wd, bs, an);
      checks++;
      if (err_cyc !== 1 || we_cyc !== -1 || bs !== 6'b000000 || an !== 0) begin
        errors++; $display("FAIL reject_%0d got err=%0d we=%0d busy=%b anomalies=%0d want 1/-1/000000/0", i, err_cyc, we_cyc, bs, an);
      end
    end
    checks++;
    if (ram[4] !== ref_mem[4]) begin
      errors++; $display("FAIL reject_mem got %h want %h", ram[4], ref_mem[4]);
    end
  endtask

  task automatic test_reset_mid_op();
    int we_cyc, err_cyc, an, we_seen; logic [7:0] wa; logic [31:0] wd, exp; logic [6:1] bs;
    preload(8'd4, 32'h11223344);
    req = 1'b1; size = 2'd0; addr = 32'h11; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, mem_we} !== 4'b0000 || mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid_op got flags=%b addr=%h wdata=%h want 0/0/0", {busy, done, err, mem_we}, mem_addr, mem_wdata);
    end
    we_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mem_we !== 1'b0) we_seen++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    if (mem_we !== 1'b0) we_seen++;
    checks++;
    if (we_seen !== 0 || ram[4] !== 32'h11223344) begin
      errors++; $display("FAIL reset_no_write got we_cycles=%0d mem=%h want 0/11223344", we_seen, ram[4]);
    end
    apply_store(2'd0, 32'h12, 32'h77, we_cyc, err_cyc, wa, wd, bs, an);
    exp = model_store(2'd0, 32'h12, 32'h77);
    checks++;
    if (we_cyc !== 3 || wd !== exp || wd !== 32'h11227744 || an !== 0) begin
      errors++; $display("FAIL after_reset_store got cyc=%0d data=%h want cyc=3 data=%h", we_cyc, wd, exp);
    end
  endtask

  // REQ stays high; operands presented while busy must be ignored.
  task automatic test_req_held();
    int          wc [$];
    logic [31:0] wv [$];
    logic [31:0] e1, e2;
    preload(8'd4, 32'h11223344);
    e1 = model_store(2'd0, 32'h10, 32'hAA);
    e2 = model_store(2'd0, 32'h13, 32'hBB);
    req = 1'b1; size = 2'd0; addr = 32'h10; wdata = 32'hAA;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (mem_we === 1'b1) begin wc.push_back(c); wv.push_back(mem_wdata); end
      if (c <= 3) begin
        size = 2'd2; addr = {$urandom_range(0, 255), 2'b00}; wdata = $urandom;
      end else if (c == 4) begin
        size = 2'd0; addr = 32'h13; wdata = 32'hBB;
      end else begin
        req = 1'b0;
      end
    end
    checks++;
    if (wc.size() != 2) begin
      errors++; $display("FAIL req_held_count got %0d writes want 2", wc.size());
    end else begin
      checks++;
      if (wc[0] != 3 || wc[1] != 7 || wv[0] !== e1 || wv[1] !== e2 || e2 !== 32'hAA2233BB) begin
        errors++; $display("FAIL req_held_data got %0d:%h %0d:%h want 3:%h 7:%h", wc[0], wv[0], wc[1], wv[1], e1, e2);
      end
    end
  endtask

  // Error followed at once by a word, then a word at minimum spacing.
  task automatic test_back_to_back();
    int          wc [$];
    logic [31:0] wv [$];
    logic [7:0]  wa [$];
    int          ec [$];
    logic [31:0] d1, d2, e1, e2;
    d1 = $urandom; d2 = $urandom;
    e1 = model_store(2'd2, 32'h20, d1);
    e2 = model_store(2'd2, 32'h24, d2);
    req = 1'b1; size = 2'd1; addr = 32'h31; wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (mem_we === 1'b1) begin wc.push_back(c); wv.push_back(mem_wdata); wa.push_back(mem_addr); end
      if (err === 1'b1) ec.push_back(c);
      case (c)
        1: begin size = 2'd2; addr = 32'h20; wdata = d1; end
        2: begin size = 2'd2; addr = 32'h28; wdata = $urandom; end
        3: begin size = 2'd2; addr = 32'h24; wdata = d2; end
        default: req = 1'b0;
      endcase
    end
    checks++;
    if (ec.size() != 1 || ec[0] != 1) begin
      errors++; $display("FAIL b2b_err got %0d pulses want one in cycle 1", ec.size());
    end
    checks++;
    if (wc.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d writes want 2", wc.size());
    end else begin
      checks++;
      if (wc[0] != 2 || wc[1] != 4 || wa[0] !== 8'd8 || wa[1] !== 8'd9 || wv[0] !== e1 || wv[1] !== e2) begin
        errors++; $display("FAIL b2b_data got %0d@%0d:%h %0d@%0d:%h want 2@8:%h 4@9:%h", wc[0], wa[0], wv[0], wc[1], wa[1], wv[1], e1, e2);
      end
    end
  endtask

  task automatic test_random();
    int we_cyc, err_cyc, an, bad_mem; logic [7:0] wa; logic [31:0] wd, exp, a, d;
    logic [6:1] bs; logic [1:0] s;
    for (int i = 0; i < 40; i++) begin
      s = 2'($urandom_range(0, 3)); a = $urandom; d = $urandom;
      if ($urandom_range(0, 1) == 1 && s == 2'd2) a[1:0] = 2'b00;
      apply_store(s, a, d, we_cyc, err_cyc, wa, wd, bs, an);
      checks++;
      if (is_valid(s, a)) begin
        exp = model_store(s, a, d);
        if (we_cyc !== ((s == 2'd2) ? 1 : 3) || wa !== a[9:2] || wd !== exp || err_cyc !== -1 ||
            bs !== ((s == 2'd2) ? 6'b000001 : 6'b000111) || an !== 0) begin
          errors++; $display("FAIL rand_store_%0d size=%0d addr=%h got cyc=%0d wa=%h wd=%h busy=%b want wa=%h wd=%h", i, s, a, we_cyc, wa, wd, bs, a[9:2], exp);
        end
      end else begin
        if (err_cyc !== 1 || we_cyc !== -1 || bs !== 6'b000000 || an !== 0) begin
          errors++; $display("FAIL rand_reject_%0d size=%0d addr=%h got err=%0d we=%0d busy=%b want 1/-1/000000", i, s, a, err_cyc, we_cyc, bs);
        end
      end
    end
    bad_mem = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad_mem++;
    checks++;
    if (bad_mem != 0) begin
      errors++; $display("FAIL final_memory got %0d differing words want 0", bad_mem);
    end
  endtask

  initial begin
    test_reset();
    test_plan_stores();
    test_errors();
    test_reset_mid_op();
    test_req_held();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
